// File: rtl/lcd_pattern_gen.sv
// Parallel-RGB LCD timing generator with built-in test patterns (bars, grid, grey ramp, white).
// Define LCD_PATTERN_SCROLL_EN to compile the per-frame horizontal scroll of the pattern.
module lcd_pattern_gen #(
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 43,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 8,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 12,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int SYNC_POL = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     mode,
  output logic           lcd_de,
  output logic           lcd_hsync,
  output logic           lcd_vsync,
  output logic [R_W-1:0] lcd_r,
  output logic [G_W-1:0] lcd_g,
  output logic [B_W-1:0] lcd_b,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned HA_U  = H_ACTIVE;
  localparam int unsigned BAR_W = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
  localparam int unsigned R_MAX = (1 << R_W) - 1;
  localparam int unsigned G_MAX = (1 << G_W) - 1;
  localparam int unsigned B_MAX = (1 << B_W) - 1;
  localparam logic        SYNC_OFF = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic [1:0]     mode_q, mode_d;
  logic           de_q, hs_q, vs_q, fs_q;
  logic [R_W-1:0] r_q, r_d;
  logic [G_W-1:0] g_q, g_d;
  logic [B_W-1:0] b_q, b_d;

  logic           at_origin, act, hs_act, vs_act;
  logic [1:0]     mode_eff;
  int unsigned    px, py, bar, r_grad, g_grad, b_grad;

  assign at_origin = (h_q == '0) && (v_q == '0);

  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    mode_d = mode_q;
    if (en) begin
      if (at_origin) mode_d = mode;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

`ifdef LCD_PATTERN_SCROLL_EN
  localparam logic [HW-1:0] OFF_LAST = HW'(H_ACTIVE - 1);
  logic [HW-1:0] off_q, off_d;
  int unsigned   x_sum;

  always_comb begin
    off_d = off_q;
    if (en && (h_q == H_LAST) && (v_q == V_LAST))
      off_d = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
    x_sum = 32'(h_q) + 32'(off_q);
    px    = (x_sum >= HA_U) ? x_sum - HA_U : x_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) off_q <= '0;
    else     off_q <= off_d;
  end
`else
  assign px = 32'(h_q);
`endif

  assign py = 32'(v_q);

  always_comb begin
    // Pixel (0,0) already uses the mode being latched so the whole frame is consistent.
    mode_eff = at_origin ? mode : mode_q;
    act      = (h_q < H_ACT) && (v_q < V_ACT);
    hs_act   = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_act   = (v_q >= VS_BEG) && (v_q < VS_END);
    bar      = px / BAR_W;
    r_grad   = (px << R_W) / HA_U;
    g_grad   = (px << G_W) / HA_U;
    b_grad   = (px << B_W) / HA_U;
    if (r_grad > R_MAX) r_grad = R_MAX;
    if (g_grad > G_MAX) g_grad = G_MAX;
    if (b_grad > B_MAX) b_grad = B_MAX;
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (mode_eff)
      2'd0: begin
        // Bar index bits map directly to absent channels: bit1 -> no red, bit2 -> no green, bit0 -> no blue.
        if (bar < 32'd8) begin
          r_d = bar[1] ? '0 : '1;
          g_d = bar[2] ? '0 : '1;
          b_d = bar[0] ? '0 : '1;
        end
      end
      2'd1: begin
        if ((px % 32'd16 == 32'd0) || (py % 32'd16 == 32'd0)) begin
          r_d = '1;
          g_d = '1;
          b_d = '1;
        end
      end
      2'd2: begin
        r_d = R_W'(r_grad);
        g_d = G_W'(g_grad);
        b_d = B_W'(b_grad);
      end
      default: begin
        r_d = '1;
        g_d = '1;
        b_d = '1;
      end
    endcase
    if (!(en && act)) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q    <= '0;
      v_q    <= '0;
      mode_q <= 2'd0;
      de_q   <= 1'b0;
      hs_q   <= SYNC_OFF;
      vs_q   <= SYNC_OFF;
      fs_q   <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      mode_q <= mode_d;
      de_q   <= en && act;
      hs_q   <= (en && hs_act) ? ~SYNC_OFF : SYNC_OFF;
      vs_q   <= (en && vs_act) ? ~SYNC_OFF : SYNC_OFF;
      fs_q   <= en && at_origin;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign lcd_de      = de_q;
  assign lcd_hsync   = hs_q;
  assign lcd_vsync   = vs_q;
  assign frame_start = fs_q;
  assign lcd_r       = r_q;
  assign lcd_g       = g_q;
  assign lcd_b       = b_q;

endmodule
